// File: rtl/ingr_dest_tag.sv
// ---------------------------------------------------------------------------
// ingr_dest_tag
//
// Ingress destination tagger for an AXI-Stream packet flow. The first beat of
// every packet latches its tid and looks up dest_enable[tid]. Every beat of
// that packet is then emitted with tid = latched tid and
// tdest = {drop, latched tid}, where drop = ~dest_enable[tid]. Beats beyond
// MAX_PKT_BEATS in a packet carry tuser=1 (oversize). tdata/tkeep/tlast pass
// through unchanged. Outputs are registered through a two-entry skid buffer:
// one cycle of latency and full throughput, with axis_in_tready driven from a
// register.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   axis_in_*           slave AXI-Stream (tdata, tid, tkeep, tlast, tvalid,
//                       tready)
//   axis_out_*          master AXI-Stream (tdata, tuser=oversize, tid,
//                       tdest={drop,tid}, tkeep, tlast, tvalid, tready)
//   dest_enable         per-tid enable; bit i clear marks tid i as dropped
//   pkt_count           packets accepted (tlast beats), wraps
//   drop_count          accepted packets tagged drop, wraps
//   oversize_count      accepted packets whose last beat is oversize, wraps
// ---------------------------------------------------------------------------
module ingr_dest_tag #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  parameter int MAX_PKT_BEATS  = 190
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
  input  logic [AXIS_ID_WIDTH-1:0]      axis_in_tid,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep,
  input  logic                          axis_in_tlast,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
  output logic                          axis_out_tuser,
  output logic [AXIS_ID_WIDTH-1:0]      axis_out_tid,
  output logic [AXIS_ID_WIDTH:0]        axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
  output logic                          axis_out_tlast,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  input  logic [(2**AXIS_ID_WIDTH)-1:0] dest_enable,
  output logic [31:0]                   pkt_count,
  output logic [31:0]                   drop_count,
  output logic [31:0]                   oversize_count
);

  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;
  localparam int DEST_W = AXIS_ID_WIDTH + 1;
  localparam int CNT_W  = $clog2(MAX_PKT_BEATS + 1);
  localparam int BEAT_W = AXIS_BUS_WIDTH + KEEP_W + 1 + 1 + AXIS_ID_WIDTH + DEST_W;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_t;

  // Beat counter stops at MAX_PKT_BEATS so it never wraps back into range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(MAX_PKT_BEATS)) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  state_t                    state;
  logic [CNT_W-1:0]          beat_cnt;
  logic [AXIS_ID_WIDTH-1:0]  tid_lat;
  logic                      drop_lat;

  logic                      in_ready_r;
  logic                      vld_p1;
  logic                      skid_vld_p1;
  logic [BEAT_W-1:0]         beat_p1;
  logic [BEAT_W-1:0]         skid_beat_p1;

  logic                      first_p0;
  logic                      accept_p0;
  logic [AXIS_ID_WIDTH-1:0]  tid_p0;
  logic                      drop_p0;
  logic                      user_p0;
  logic [BEAT_W-1:0]         beat_p0;
  logic                      out_load;

  // ---- stage p0: tag the incoming beat ----
  assign first_p0  = (state == ST_FIRST);
  assign accept_p0 = axis_in_tvalid & in_ready_r;
  assign tid_p0    = first_p0 ? axis_in_tid : tid_lat;
  assign drop_p0   = first_p0 ? ~dest_enable[axis_in_tid] : drop_lat;
  // beat_cnt holds the number of earlier beats, so this beat's 1-based index
  // exceeds the limit exactly when the counter has reached it.
  assign user_p0   = (beat_cnt == CNT_W'(MAX_PKT_BEATS));
  assign beat_p0   = {axis_in_tdata, axis_in_tkeep, axis_in_tlast, user_p0,
                      tid_p0, drop_p0, tid_p0};

  // Output register may take a new beat when empty or being drained.
  assign out_load  = ~vld_p1 | axis_out_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= ST_FIRST;
      beat_cnt       <= '0;
      in_ready_r     <= 1'b0;
      vld_p1         <= 1'b0;
      skid_vld_p1    <= 1'b0;
      pkt_count      <= '0;
      drop_count     <= '0;
      oversize_count <= '0;
    end else begin
      if (accept_p0) begin
        if (axis_in_tlast) begin
          state     <= ST_FIRST;
          beat_cnt  <= '0;
          pkt_count <= pkt_count + 32'd1;
          if (drop_p0) begin
            drop_count <= drop_count + 32'd1;
          end
          if (user_p0) begin
            oversize_count <= oversize_count + 32'd1;
          end
        end else begin
          state    <= ST_MID;
          beat_cnt <= sat_inc(beat_cnt);
        end
      end

      // in_ready_r always tracks "skid entry will be empty next cycle".
      if (out_load) begin
        vld_p1      <= skid_vld_p1 | accept_p0;
        skid_vld_p1 <= 1'b0;
        in_ready_r  <= 1'b1;
      end else if (accept_p0) begin
        skid_vld_p1 <= 1'b1;
        in_ready_r  <= 1'b0;
      end
    end
  end

  // ---- stage p1: output register and skid entry ----
  always_ff @(posedge aclk) begin
    if (accept_p0 && first_p0) begin
      tid_lat  <= axis_in_tid;
      drop_lat <= ~dest_enable[axis_in_tid];
    end
    if (out_load) begin
      // The skid entry is older than anything on the input, so it goes first.
      beat_p1 <= skid_vld_p1 ? skid_beat_p1 : beat_p0;
    end else if (accept_p0) begin
      skid_beat_p1 <= beat_p0;
    end
  end

  assign axis_in_tready  = in_ready_r;
  assign axis_out_tvalid = vld_p1;
  assign {axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tuser,
          axis_out_tid, axis_out_tdest} = beat_p1;

endmodule

// File: tb/tb_ingr_dest_tag.sv
module tb_ingr_dest_tag;

  localparam int BW   = 64;
  localparam int IW   = 4;
  localparam int MAXB = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [BW-1:0] axis_in_tdata;
  logic [IW-1:0] axis_in_tid;
  logic [7:0]    axis_in_tkeep;
  logic          axis_in_tlast;
  logic          axis_in_tvalid;
  logic          axis_in_tready;
  logic [BW-1:0] axis_out_tdata;
  logic          axis_out_tuser;
  logic [IW-1:0] axis_out_tid;
  logic [IW:0]   axis_out_tdest;
  logic [7:0]    axis_out_tkeep;
  logic          axis_out_tlast;
  logic          axis_out_tvalid;
  logic          axis_out_tready;
  logic [15:0]   dest_enable;
  logic [31:0]   pkt_count;
  logic [31:0]   drop_count;
  logic [31:0]   oversize_count;

  always #5 aclk = ~aclk;

  ingr_dest_tag #(
    .AXIS_BUS_WIDTH(BW),
    .AXIS_ID_WIDTH (IW),
    .MAX_PKT_BEATS (MAXB)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .axis_in_tdata  (axis_in_tdata),
    .axis_in_tid    (axis_in_tid),
    .axis_in_tkeep  (axis_in_tkeep),
    .axis_in_tlast  (axis_in_tlast),
    .axis_in_tvalid (axis_in_tvalid),
    .axis_in_tready (axis_in_tready),
    .axis_out_tdata (axis_out_tdata),
    .axis_out_tuser (axis_out_tuser),
    .axis_out_tid   (axis_out_tid),
    .axis_out_tdest (axis_out_tdest),
    .axis_out_tkeep (axis_out_tkeep),
    .axis_out_tlast (axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready),
    .dest_enable    (dest_enable),
    .pkt_count      (pkt_count),
    .drop_count     (drop_count),
    .oversize_count (oversize_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic [3:0]  tid;
    logic [4:0]  dest;
  } beat_t;

  typedef struct {
    logic [3:0]  tid;
    logic        last;
    logic [15:0] de;
    logic [4:0]  exp_dest;
    logic [3:0]  exp_tid;
    logic        exp_user;
    bit          chk_cnt;
    logic [31:0] exp_pkt;
    logic [31:0] exp_drop;
    logic [31:0] exp_ovs;
  } vec_t;

  int    n_cmp  = 0;
  int    n_fail = 0;
  vec_t  tbl[$];
  beat_t exp_q[$];

  // Reference model state
  bit          m_first;
  logic [3:0]  m_tid;
  logic        m_drop;
  int          m_idx;
  logic [31:0] m_pkts, m_drops, m_ovs;
  bit          stall_prev;
  beat_t       held;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic add(input logic [3:0] tid, input logic last, input logic [15:0] de,
                     input logic [4:0] edst, input logic [3:0] etid, input logic eusr,
                     input bit cc, input int ep, input int ed, input int eo);
    vec_t v;
    v.tid = tid; v.last = last; v.de = de;
    v.exp_dest = edst; v.exp_tid = etid; v.exp_user = eusr;
    v.chk_cnt = cc; v.exp_pkt = 32'(ep); v.exp_drop = 32'(ed); v.exp_ovs = 32'(eo);
    tbl.push_back(v);
  endtask

  function automatic logic [63:0] dat(input int i);
    return {32'hD0D0_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
  endfunction

  function automatic logic [7:0] kp(input int i);
    return 8'hFF >> (i % 4);
  endfunction

  function automatic beat_t out_beat();
    beat_t b;
    b.data = axis_out_tdata;
    b.keep = axis_out_tkeep;
    b.last = axis_out_tlast;
    b.user = axis_out_tuser;
    b.tid  = axis_out_tid;
    b.dest = axis_out_tdest;
    return b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_first    = 1'b1;
    m_idx      = 0;
    m_pkts     = '0;
    m_drops    = '0;
    m_ovs      = '0;
    stall_prev = 1'b0;
  endtask

  task automatic model_accept();
    beat_t b;
    if (m_first) begin
      m_tid  = axis_in_tid;
      m_drop = ~dest_enable[axis_in_tid];
      m_idx  = 1;
    end else begin
      m_idx++;
    end
    b.data = axis_in_tdata;
    b.keep = axis_in_tkeep;
    b.last = axis_in_tlast;
    b.user = (m_idx > MAXB);
    b.tid  = m_tid;
    b.dest = {m_drop, m_tid};
    exp_q.push_back(b);
    if (axis_in_tlast) begin
      m_pkts++;
      if (m_drop) m_drops++;
      if (b.user) m_ovs++;
      m_first = 1'b1;
    end else begin
      m_first = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs already driven; evaluates the
  // handshakes that will occur at the next rising edge, then advances to the
  // following falling edge.
  task automatic step(output bit acc);
    beat_t cur, e;
    cur = out_beat();
    acc = axis_in_tvalid && axis_in_tready;
    if (stall_prev) chk("hold", 128'({axis_out_tvalid, cur}), 128'({1'b1, held}));
    if (axis_out_tvalid && axis_out_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_beat: got %0h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 128'(cur), 128'(e));
      end
    end
    if (acc) model_accept();
    stall_prev = axis_out_tvalid && !axis_out_tready;
    held = cur;
    @(negedge aclk);
  endtask

  initial begin
    bit   acc;
    vec_t v;
    int   cyc, r_pkt, r_beat, r_len;

    areset          = 1'b1;
    axis_in_tdata   = '0;
    axis_in_tid     = '0;
    axis_in_tkeep   = '0;
    axis_in_tlast   = 1'b0;
    axis_in_tvalid  = 1'b0;
    axis_out_tready = 1'b0;
    dest_enable     = 16'hFFFF;
    model_reset();

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_out_tvalid", 128'(axis_out_tvalid), 128'(0));
    chk("rst_in_tready", 128'(axis_in_tready), 128'(0));
    chk("rst_pkt_count", 128'(pkt_count), 128'(0));
    chk("rst_drop_count", 128'(drop_count), 128'(0));
    chk("rst_ovs_count", 128'(oversize_count), 128'(0));
    areset = 1'b0;
    @(negedge aclk);
    chk("in_tready_after_reset", 128'(axis_in_tready), 128'(1));

    // Directed table (MAX_PKT_BEATS = 4)
    // 3-beat tid 5, all enabled
    add(4'd5, 1'b0, 16'hFFFF, 5'h05, 4'd5, 1'b0, 0, 0, 0, 0);
    add(4'd5, 1'b0, 16'hFFFF, 5'h05, 4'd5, 1'b0, 0, 0, 0, 0);
    add(4'd5, 1'b1, 16'hFFFF, 5'h05, 4'd5, 1'b0, 1, 1, 0, 0);
    // tid 5 disabled on first beat; later tid / enable changes ignored
    add(4'd5, 1'b0, 16'hFFDF, 5'h15, 4'd5, 1'b0, 0, 0, 0, 0);
    add(4'd7, 1'b0, 16'hFFFF, 5'h15, 4'd5, 1'b0, 0, 0, 0, 0);
    add(4'd7, 1'b1, 16'hFFDF, 5'h15, 4'd5, 1'b0, 1, 2, 1, 0);
    // 6-beat oversize packet tid 2
    add(4'd2, 1'b0, 16'hFFFF, 5'h02, 4'd2, 1'b0, 0, 0, 0, 0);
    add(4'd2, 1'b0, 16'hFFFF, 5'h02, 4'd2, 1'b0, 0, 0, 0, 0);
    add(4'd2, 1'b0, 16'hFFFF, 5'h02, 4'd2, 1'b0, 0, 0, 0, 0);
    add(4'd2, 1'b0, 16'hFFFF, 5'h02, 4'd2, 1'b0, 0, 0, 0, 0);
    add(4'd2, 1'b0, 16'hFFFF, 5'h02, 4'd2, 1'b1, 0, 0, 0, 0);
    add(4'd2, 1'b1, 16'hFFFF, 5'h02, 4'd2, 1'b1, 1, 3, 1, 1);
    // following 2-beat packet is not oversize
    add(4'hA, 1'b0, 16'hFFFF, 5'h0A, 4'hA, 1'b0, 0, 0, 0, 0);
    add(4'hA, 1'b1, 16'hFFFF, 5'h0A, 4'hA, 1'b0, 1, 4, 1, 1);
    // back-to-back single-beat packets, first one dropped
    add(4'hF, 1'b1, 16'h7FFF, 5'h1F, 4'hF, 1'b0, 1, 5, 2, 1);
    add(4'h1, 1'b1, 16'hFFFF, 5'h01, 4'h1, 1'b0, 1, 6, 2, 1);

    axis_out_tready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      axis_in_tvalid = 1'b1;
      axis_in_tid    = v.tid;
      axis_in_tlast  = v.last;
      dest_enable    = v.de;
      axis_in_tdata  = dat(i);
      axis_in_tkeep  = kp(i);
      step(acc);
      chk($sformatf("tbl%0d_accept", i), 128'(acc), 128'(1));
      chk($sformatf("tbl%0d_tvalid", i), 128'(axis_out_tvalid), 128'(1));
      chk($sformatf("tbl%0d_tdest", i), 128'(axis_out_tdest), 128'(v.exp_dest));
      chk($sformatf("tbl%0d_tid", i), 128'(axis_out_tid), 128'(v.exp_tid));
      chk($sformatf("tbl%0d_tuser", i), 128'(axis_out_tuser), 128'(v.exp_user));
      chk($sformatf("tbl%0d_data", i),
          128'({axis_out_tdata, axis_out_tkeep, axis_out_tlast}),
          128'({dat(i), kp(i), v.last}));
      if (v.chk_cnt) begin
        chk($sformatf("tbl%0d_pkt_count", i), 128'(pkt_count), 128'(v.exp_pkt));
        chk($sformatf("tbl%0d_drop_count", i), 128'(drop_count), 128'(v.exp_drop));
        chk($sformatf("tbl%0d_ovs_count", i), 128'(oversize_count), 128'(v.exp_ovs));
      end
    end
    axis_in_tvalid = 1'b0;
    step(acc);
    step(acc);
    chk("tbl_drain", 128'(axis_out_tvalid), 128'(0));
    chk("tbl_queue_empty", 128'(exp_q.size()), 128'(0));

    // Reset in the middle of a 4-beat packet
    dest_enable    = 16'hFFFF;
    axis_in_tvalid = 1'b1;
    axis_in_tid    = 4'd9;
    axis_in_tlast  = 1'b0;
    axis_in_tdata  = dat(50);
    axis_in_tkeep  = 8'hFF;
    step(acc);
    axis_in_tdata  = dat(51);
    #2 areset = 1'b1;
    #1;
    chk("midrst_out_tvalid", 128'(axis_out_tvalid), 128'(0));
    chk("midrst_in_tready", 128'(axis_in_tready), 128'(0));
    chk("midrst_pkt_count", 128'(pkt_count), 128'(0));
    chk("midrst_drop_count", 128'(drop_count), 128'(0));
    chk("midrst_ovs_count", 128'(oversize_count), 128'(0));
    axis_in_tvalid = 1'b0;
    model_reset();
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("midrst_in_tready_up", 128'(axis_in_tready), 128'(1));
    axis_in_tvalid = 1'b1;
    axis_in_tid    = 4'd3;
    axis_in_tlast  = 1'b0;
    axis_in_tdata  = dat(100);
    step(acc);
    chk("post_rst_b1_tdest", 128'({axis_out_tvalid, axis_out_tdest}), 128'({1'b1, 5'h03}));
    chk("post_rst_b1_tuser", 128'(axis_out_tuser), 128'(0));
    axis_in_tid    = 4'd6;
    axis_in_tlast  = 1'b1;
    axis_in_tdata  = dat(101);
    step(acc);
    chk("post_rst_b2_tdest", 128'({axis_out_tvalid, axis_out_tdest, axis_out_tid}),
        128'({1'b1, 5'h03, 4'd3}));
    chk("post_rst_b2_tuser", 128'(axis_out_tuser), 128'(0));
    chk("post_rst_pkt_count", 128'(pkt_count), 128'(1));
    axis_in_tvalid = 1'b0;
    step(acc);

    // Random valid/ready over 1000 packets
    cyc = 0; r_pkt = 0; r_beat = 0; r_len = 1;
    while ((r_pkt < 1000 || axis_in_tvalid || exp_q.size() != 0) && cyc < 60000) begin
      if (!axis_in_tvalid && r_pkt < 1000 && $urandom_range(0, 1) == 1) begin
        if (r_beat == 0) r_len = $urandom_range(1, 6);
        axis_in_tdata  = {$urandom, $urandom};
        axis_in_tkeep  = 8'($urandom);
        axis_in_tid    = 4'($urandom);
        axis_in_tlast  = (r_beat == r_len - 1);
        axis_in_tvalid = 1'b1;
        if (axis_in_tlast) begin
          r_beat = 0;
          r_pkt++;
        end else begin
          r_beat++;
        end
      end
      dest_enable     = 16'($urandom);
      axis_out_tready = ($urandom_range(0, 1) == 1);
      step(acc);
      cyc++;
      if (acc) axis_in_tvalid = 1'b0;
    end
    chk("rand_within_budget", 128'(cyc < 60000), 128'(1));
    chk("rand_pkt_count", 128'(pkt_count), 128'(1001));
    chk("rand_drop_count", 128'(drop_count), 128'(m_drops));
    chk("rand_ovs_count", 128'(oversize_count), 128'(m_ovs));
    chk("rand_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
